imem_loader: RTL and testbench

- Program loader: the write-side counterpart to the 256 x 16-bit read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake (from the UART RX / debug link) and assembles 16-bit instruction words.
- Drives the instruction memory's write port, then verifies a checksum.
- Holds the CPU core in reset (cpu_hold) until a load completes successfully.

---
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader - byte-stream program loader for the 256 x 16 instruction memory
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter bit         HI_FIRST  = 1'b1,
  parameter bit         BOOT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold,
  output logic [8:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    BYTE0 = 3'd2,
    BYTE1 = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [8:0]  remaining;
  logic [7:0]  addr;
  logic [7:0]  sum;
  logic [15:0] wdata;
  logic        begin_load;

  assign begin_load = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign mem_addr   = addr;
  assign mem_wdata  = wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // in_ready is 1 in every state that consumes bytes, so in_valid alone marks a transfer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start)    state_nx = COUNT;
      COUNT:           if (in_valid) state_nx = BYTE0;
      BYTE0:           if (in_valid) state_nx = BYTE1;
      BYTE1:           if (in_valid) state_nx = WRITE;
      WRITE:           state_nx = (remaining == 9'd1) ? CHECK : BYTE0;
      CHECK:           if (in_valid) state_nx = (in_data == sum) ? DONE : ERR;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      IDLE:                cpu_hold = BOOT_HOLD;
      COUNT, BYTE0, BYTE1,
      CHECK:               begin in_ready = 1'b1; busy = 1'b1; end
      WRITE:               begin mem_we = 1'b1; busy = 1'b1; end
      DONE:                begin done = 1'b1; cpu_hold = 1'b0; end
      ERR:                 err = 1'b1;
      default:             ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining    <= 9'd0;
      addr         <= BASE_ADDR;
      sum          <= 8'd0;
      wdata        <= 16'd0;
      words_loaded <= 9'd0;
    end else begin
      if (begin_load) begin
        words_loaded <= 9'd0;
        sum          <= 8'd0;
        addr         <= BASE_ADDR;
      end
      case (state)
        // a count byte of zero means 256 words
        COUNT: if (in_valid) remaining <= {(in_data == 8'd0), in_data};
        BYTE0: if (in_valid) begin
          sum <= sum + in_data;
          if (HI_FIRST) wdata[15:8] <= in_data;
          else          wdata[7:0]  <= in_data;
        end
        BYTE1: if (in_valid) begin
          sum <= sum + in_data;
          if (HI_FIRST) wdata[7:0]  <= in_data;
          else          wdata[15:8] <= in_data;
        end
        WRITE: begin
          words_loaded <= words_loaded + 9'd1;
          addr         <= addr + 8'd1;
          remaining    <= remaining - 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_loader - randomized bench for imem_loader against a frame-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk;
  logic [2:0]  rst_n, start, in_valid;
  logic [2:0]  in_ready, mem_we, busy, done, err, cpu_hold;
  logic [7:0]  in_data      [3];
  logic [7:0]  mem_addr     [3];
  logic [15:0] mem_wdata    [3];
  logic [8:0]  words_loaded [3];

  logic [7:0]  base_t [3] = '{8'h00, 8'hFE, 8'h00};
  logic        hi_t   [3] = '{1'b1, 1'b1, 1'b0};
  logic        boot_t [3] = '{1'b1, 1'b1, 1'b0};

  int          total = 0;
  int          bad   = 0;
  int          sel   = 0;
  logic [7:0]  frame [$];
  logic [31:0] exp_q [$];

  imem_loader #(.BASE_ADDR(8'h00), .HI_FIRST(1'b1), .BOOT_HOLD(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .cpu_hold(cpu_hold[0]),
    .words_loaded(words_loaded[0]));

  imem_loader #(.BASE_ADDR(8'hFE), .HI_FIRST(1'b1), .BOOT_HOLD(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .cpu_hold(cpu_hold[1]),
    .words_loaded(words_loaded[1]));

  imem_loader #(.BASE_ADDR(8'h00), .HI_FIRST(1'b0), .BOOT_HOLD(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .in_valid(in_valid[2]),
    .in_data(in_data[2]), .in_ready(in_ready[2]), .mem_we(mem_we[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .busy(busy[2]),
    .done(done[2]), .err(err[2]), .cpu_hold(cpu_hold[2]),
    .words_loaded(words_loaded[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (inst %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // every write pulse of the selected loader must match the next expected {addr,data}
  always @(negedge clk) begin
    if ((mem_we & ~(3'b001 << sel)) != 3'b000)
      chk("idle_inst_write", 32'(mem_we), 32'(3'b001 << sel));
    if (mem_we[sel]) begin
      if (exp_q.size() == 0) chk("spurious_write", {8'h00, mem_addr[sel], mem_wdata[sel]}, 32'hFFFF_FFFF);
      else chk("write", {8'h00, mem_addr[sel], mem_wdata[sel]}, exp_q.pop_front());
    end
  end

  task automatic make_frame(input logic [7:0] n, input bit good);
    int          cnt;
    logic [7:0]  s;
    logic [7:0]  b;
    frame.delete();
    frame.push_back(n);
    cnt = (n == 8'd0) ? 256 : int'(n);
    s = 8'd0;
    for (int i = 0; i < 2 * cnt; i++) begin
      b = 8'($urandom);
      s = s + b;
      frame.push_back(b);
    end
    frame.push_back(good ? s : (s ^ 8'($urandom_range(1, 255))));
  endtask

  // frame-level reference: expected writes, success flag and word count
  task automatic model(output bit ok, output int n);
    logic [7:0] s;
    logic [7:0] b0, b1, a;
    n = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      b0 = frame[1 + 2 * i];
      b1 = frame[2 + 2 * i];
      s  = s + b0 + b1;
      a  = base_t[sel] + 8'(i);
      exp_q.push_back({8'h00, a, hi_t[sel] ? {b0, b1} : {b1, b0}});
    end
    ok = (frame[2 * n + 1] == s);
  endtask

  task automatic pulse_start();
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
  endtask

  task automatic send_bytes(input bit rnd, input int nbytes);
    bit acc;
    for (int k = 0; k < nbytes; k++) begin
      if (rnd) repeat ($urandom_range(0, 3)) begin
        start[sel] = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end
      in_valid[sel] = 1'b1;
      in_data[sel]  = frame[k];
      for (int t = 0; ; t++) begin
        acc = in_ready[sel];
        if (rnd) start[sel] = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        if (acc) break;
        if (t > 200) begin
          chk("ready_timeout", 32'd0, 32'd1);
          break;
        end
      end
      in_valid[sel] = 1'b0;
      start[sel]    = 1'b0;
    end
  endtask

  task automatic run_frame(input bit rnd, input bit exp_ok, input int exp_words);
    pulse_start();
    chk("busy_after_start", 32'(busy[sel]), 32'd1);
    chk("ready_in_count", 32'(in_ready[sel]), 32'd1);
    chk("words_cleared", 32'(words_loaded[sel]), 32'd0);
    chk("flags_cleared", {30'd0, done[sel], err[sel]}, 32'd0);
    chk("hold_while_busy", 32'(cpu_hold[sel]), 32'd1);
    send_bytes(rnd, frame.size());
    chk("done", 32'(done[sel]), 32'(exp_ok));
    chk("err", 32'(err[sel]), 32'(!exp_ok));
    chk("cpu_hold_end", 32'(cpu_hold[sel]), 32'(!exp_ok));
    chk("busy_end", 32'(busy[sel]), 32'd0);
    chk("ready_end", 32'(in_ready[sel]), 32'd0);
    chk("words_loaded", 32'(words_loaded[sel]), 32'(exp_words));
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset(input int i);
    chk("rst_busy", 32'(busy[i]), 32'd0);
    chk("rst_ready_we", {30'd0, in_ready[i], mem_we[i]}, 32'd0);
    chk("rst_flags", {30'd0, done[i], err[i]}, 32'd0);
    chk("rst_words", 32'(words_loaded[i]), 32'd0);
    chk("rst_addr", 32'(mem_addr[i]), 32'(base_t[i]));
    chk("rst_wdata", 32'(mem_wdata[i]), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold[i]), 32'(boot_t[i]));
  endtask

  initial begin
    bit ok;
    int n;
    rst_n    = 3'b000;
    start    = 3'b000;
    in_valid = 3'b000;
    for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_reset(i);
    rst_n = 3'b111;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check_reset(i);

    // directed good frame, hi-first
    sel = 0;
    frame = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF};
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0001_ABCD);
    exp_q.push_back(32'h0002_0001);
    run_frame(1'b0, 1'b1, 3);

    // same words, wrong checksum: writes still happen, load fails
    frame[7] = 8'h00;
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0001_ABCD);
    exp_q.push_back(32'h0002_0001);
    run_frame(1'b0, 1'b0, 3);

    // reload after an error
    frame[7] = 8'hBF;
    model(ok, n);
    run_frame(1'b1, ok, n);

    // address wrap and the 256-word count
    sel = 1;
    make_frame(8'd3, 1'b1);
    model(ok, n);
    run_frame(1'b0, ok, n);
    make_frame(8'd0, 1'b1);
    model(ok, n);
    run_frame(1'b0, ok, n);

    // random frames with valid gaps and stray start pulses
    sel = 0;
    for (int f = 0; f < 8; f++) begin
      make_frame(8'($urandom_range(1, 6)), $urandom_range(0, 3) != 0);
      model(ok, n);
      run_frame(1'b1, ok, n);
    end

    // reset right after the third byte of a 4-word load
    make_frame(8'd4, 1'b1);
    exp_q.push_back({16'h0000, frame[1], frame[2]});
    pulse_start();
    send_bytes(1'b0, 3);
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    check_reset(0);
    chk("writes_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    model(ok, n);
    run_frame(1'b1, ok, n);

    // low-byte-first loader without boot hold
    sel = 2;
    frame = '{8'h01, 8'h12, 8'h34, 8'h46};
    exp_q.push_back(32'h0000_3412);
    run_frame(1'b0, 1'b1, 1);
    make_frame(8'($urandom_range(1, 5)), 1'b1);
    model(ok, n);
    run_frame(1'b1, ok, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
